pll_reset_ctrl: RTL

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a synchronized and stable lock,
// then releases the system reset; retries on lock timeout and counts lock losses.
module pll_reset_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 270000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 2700,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    localparam int unsigned MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int unsigned CW     = $clog2(MAX_P + 1);
    localparam int unsigned RW     = $clog2(MAX_RETRIES + 2);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [RW-1:0]   retry_q, retry_n;
    logic [1:0]      sync_q;
    logic            lock_s;
    logic            lost_inc;

    assign lock_s = sync_q[1];
    assign state  = state_q;

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        retry_n  = retry_q;
        lost_inc = 1'b0;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_n = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_n = FAIL;
                    end else begin
                        state_n = PLL_RST;
                        retry_n = retry_q + RW'(1);
                    end
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    retry_n = '0;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    state_n  = PLL_RST;
                    lost_inc = 1'b1;
                end
            end
            FAIL: begin
                cnt_n = '0;
            end
            default: begin
                state_n = PLL_RST;
                cnt_n   = '0;
            end
        endcase
        // restart overrides every transition, but a coincident lock loss is still counted
        if (restart) begin
            state_n = PLL_RST;
            cnt_n   = '0;
            retry_n = '0;
        end
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            lost_cnt  <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], pll_lock};
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            retry_q   <= retry_n;
            if (lost_inc && (lost_cnt != '1)) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
            pll_reset <= (state_n == PLL_RST) || (state_n == FAIL);
            sys_rst   <= (state_n != RUN);
            ready     <= (state_n == RUN);
            fail      <= (state_n == FAIL);
        end
    end

endmodule
